// File: rtl/vdf_3_a_collector_pkg.sv
// Shared constants and the word+length entry type for the VDF chain collector.
// The chain latency is fixed by the upstream 3-stage gated DFF pipeline.
package vdf_pkg;

    localparam int VDF_CHAIN_LATENCY = 3;
    localparam int VDF_WORD_W        = 8;
    localparam int VDF_CNT_W         = 16;
    localparam int VDF_LEN_W         = $clog2(VDF_WORD_W + 1);

    typedef struct packed {
        logic [VDF_LEN_W-1:0]  len;
        logic [VDF_WORD_W-1:0] word;
    } vdf_entry_t;

endpackage

// File: rtl/vdf_3_a_collector_if.sv
// Packed-word output channel of the collector: data, length and valid/ready handshake.
interface vdf_3_a_collector_if #(
    parameter int WORD_W = 8
) ();

    localparam int LEN_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] WORD;
    logic [LEN_W-1:0]  WORD_LEN;
    logic              WORD_VALID;
    logic              WORD_READY;

    modport master (
        output WORD,
        output WORD_LEN,
        output WORD_VALID,
        input  WORD_READY
    );

    modport slave (
        input  WORD,
        input  WORD_LEN,
        input  WORD_VALID,
        output WORD_READY
    );

endinterface

// File: rtl/vdf_3_a_collector_word_fifo.sv
// Two-entry synchronous FIFO whose head entry is held in a register so it can
// drive the output bus directly.
module vdf_word_fifo
    import vdf_pkg::*;
#(
    parameter type entry_t = vdf_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    entry_t slot0_q, slot0_d;
    entry_t slot1_q, slot1_d;
    logic   valid0_q, valid0_d;
    logic   valid1_q, valid1_d;
    logic   do_pop;
    logic   do_push;

    assign full  = valid0_q & valid1_q;
    assign empty = ~valid0_q;
    assign head  = slot0_q;

    // A pop frees the head slot first, so a push on a full buffer still fits.
    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        valid0_d = valid0_q;
        valid1_d = valid1_q;
        do_pop   = pop & valid0_q;
        do_push  = push & (~(valid0_q & valid1_q) | do_pop);

        if (do_pop) begin
            slot0_d  = slot1_q;
            valid0_d = valid1_q;
            valid1_d = 1'b0;
            if (do_push) begin
                if (valid1_q) begin
                    slot1_d  = push_data;
                    valid1_d = 1'b1;
                end else begin
                    slot0_d  = push_data;
                    valid0_d = 1'b1;
                end
            end
        end else if (do_push) begin
            if (!valid0_q) begin
                slot0_d  = push_data;
                valid0_d = 1'b1;
            end else begin
                slot1_d  = push_data;
                valid1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
        end
    end

endmodule

// File: rtl/vdf_3_a_collector.sv
// Collects the single-bit OUT of the 3-stage gated DFF chain, packs valid samples
// LSB-first into words, and keeps a saturating ones count and a sticky drop flag.
module vdf_3_a_collector
    import vdf_pkg::*;
#(
    parameter int LATENCY = VDF_CHAIN_LATENCY,
    parameter int WORD_W  = VDF_WORD_W,
    parameter int CNT_W   = VDF_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LAUNCH,
    input  logic                  OUT_IN,
    input  logic                  FLUSH,
    vdf_3_a_collector_if.master   wbus,
    output logic [CNT_W-1:0]      ONES_COUNT,
    output logic                  DROP_ERR
);

    localparam int LEN_W = $clog2(WORD_W + 1);
    localparam int IDX_W = $clog2(WORD_W);

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [WORD_W-1:0] word;
    } entry_t;

    logic [LATENCY-1:0] launch_q, launch_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic               drop_q, drop_d;

    logic               sample;
    logic [WORD_W-1:0]  asm_s;
    logic [LEN_W-1:0]   len_s;
    logic               complete;
    logic               push;
    entry_t             push_entry;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    entry_t             head;

    assign sample = launch_q[LATENCY-1];

    // The launch delay line mirrors the chain latency so its tap marks a valid OUT.
    always_comb begin
        launch_d    = '0;
        launch_d[0] = LAUNCH;
        for (int i = 1; i < LATENCY; i++) begin
            launch_d[i] = launch_q[i-1];
        end
    end

    // A same-cycle sample lands in the word before any flush or completion push.
    always_comb begin
        asm_s      = asm_q;
        len_s      = LEN_W'(idx_q);
        asm_d      = asm_q;
        idx_d      = idx_q;
        push       = 1'b0;
        push_entry = '0;
        complete   = sample && (idx_q == IDX_W'(WORD_W - 1));

        if (sample) begin
            asm_s[idx_q] = OUT_IN;
            len_s        = LEN_W'(idx_q) + LEN_W'(1);
        end

        if (complete || (FLUSH && (len_s != '0))) begin
            push            = 1'b1;
            push_entry.word = asm_s;
            push_entry.len  = len_s;
            asm_d           = '0;
            idx_d           = '0;
        end else if (sample) begin
            asm_d = asm_s;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        ones_d = ones_q;
        if (sample && OUT_IN && (ones_q != '1)) begin
            ones_d = ones_q + CNT_W'(1);
        end
        drop_d = drop_q | (push & fifo_full & ~pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            launch_q <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
            ones_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            launch_q <= launch_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            ones_q   <= ones_d;
            drop_q   <= drop_d;
        end
    end

    assign pop = wbus.WORD_VALID & wbus.WORD_READY;

    vdf_word_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign wbus.WORD       = head.word;
    assign wbus.WORD_LEN   = head.len;
    assign wbus.WORD_VALID = ~fifo_empty;
    assign ONES_COUNT      = ones_q;
    assign DROP_ERR        = drop_q;

endmodule

// File: tb/tb_vdf_3_a_collector.sv
// Scoreboard bench for vdf_3_a_collector: directed launch/sample vectors push expected
// words into a queue, and a negedge monitor compares every handshake and status probe.
module tb_vdf_3_a_collector;

    localparam int LAT = 3;

    typedef struct {
        logic [7:0] word;
        logic [3:0] len;
    } exp_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } probe_t;

    logic        clk;
    logic        rst;
    logic        launch;
    logic        out_in;
    logic        flush;
    logic [15:0] ones;
    logic        drop;
    logic [3:0]  sat_ones;
    logic        sat_drop;

    int checks;
    int errors;

    exp_t   exp_q[$];
    probe_t chk_q[$];

    vdf_3_a_collector_if #(.WORD_W(8)) bus ();
    vdf_3_a_collector_if #(.WORD_W(8)) sat_bus ();

    assign sat_bus.WORD_READY = 1'b1;

    vdf_3_a_collector #(.LATENCY(3), .WORD_W(8), .CNT_W(16)) dut (
        .CLK        (clk),
        .RST        (rst),
        .LAUNCH     (launch),
        .OUT_IN     (out_in),
        .FLUSH      (flush),
        .wbus       (bus),
        .ONES_COUNT (ones),
        .DROP_ERR   (drop)
    );

    vdf_3_a_collector #(.LATENCY(3), .WORD_W(8), .CNT_W(4)) sat_dut (
        .CLK        (clk),
        .RST        (rst),
        .LAUNCH     (launch),
        .OUT_IN     (out_in),
        .FLUSH      (flush),
        .wbus       (sat_bus),
        .ONES_COUNT (sat_ones),
        .DROP_ERR   (sat_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every handshake pops one expected word; queued probes are evaluated here too.
    always @(negedge clk) begin
        if (bus.WORD_VALID && bus.WORD_READY && !rst) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL unexpected_word actual=%02h/%0d required=none", bus.WORD, bus.WORD_LEN);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.WORD !== e.word || bus.WORD_LEN !== e.len) begin
                    errors = errors + 1;
                    $display("[TB] FAIL word actual=%02h/%0d required=%02h/%0d",
                             bus.WORD, bus.WORD_LEN, e.word, e.len);
                end
            end
        end
        while (chk_q.size() > 0) begin
            probe_t      p;
            logic [31:0] act;
            p = chk_q.pop_front();
            case (p.sel)
                0:       act = 32'(ones);
                1:       act = 32'(drop);
                2:       act = 32'(bus.WORD_VALID);
                3:       act = 32'(bus.WORD);
                4:       act = 32'(bus.WORD_LEN);
                5:       act = 32'(sat_ones);
                default: act = 32'(exp_q.size());
            endcase
            checks = checks + 1;
            if (act !== p.exp) begin
                errors = errors + 1;
                $display("[TB] FAIL %s actual=%0h required=%0h", p.name, act, p.exp);
            end
        end
    end

    task automatic check_output(input string name, input int sel, input logic [31:0] exp);
        probe_t p;
        p.name = name;
        p.sel  = sel;
        p.exp  = exp;
        chk_q.push_back(p);
    endtask

    task automatic expect_word(input logic [7:0] w, input logic [3:0] l);
        exp_t e;
        e.word = w;
        e.len  = l;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int k);
        launch = 1'b0;
        flush  = 1'b0;
        out_in = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        launch = 1'b0;
        flush  = 1'b0;
        out_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // flush_mode: 0 none, 1 flush with the last sample, 2 flush the cycle after it.
    task automatic apply_stimulus(input logic [31:0] bits, input int n, input int flush_mode,
                                  input int rdy_pulse);
        for (int t = 0; t < n + LAT; t++) begin
            int s;
            s      = t - LAT;
            launch = (t < n);
            out_in = (s >= 0) ? bits[s] : 1'b1;
            flush  = (flush_mode == 1) && (s == n - 1);
            if (rdy_pulse >= 0) bus.WORD_READY = (t == rdy_pulse);
            @(posedge clk); #1;
        end
        launch = 1'b0;
        out_in = 1'b0;
        flush  = 1'b0;
        if (flush_mode == 2) begin
            flush  = 1'b1;
            out_in = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        if (rdy_pulse >= 0) bus.WORD_READY = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.WORD_READY = 1'b1;
        do_reset();
        check_output("reset_valid", 2, 0);
        check_output("reset_word", 3, 0);
        check_output("reset_len", 4, 0);
        check_output("reset_ones", 0, 0);
        check_output("reset_drop", 1, 0);

        // Reset mid-flight discards both launches.
        launch = 1'b1; out_in = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; launch = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check_output("midflight_valid", 2, 0);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        idle(2);
        check_output("midflight_ones", 0, 0);
        check_output("midflight_valid_after_flush", 2, 0);

        // Full word 1,0,1,1,0,0,0,1.
        expect_word(8'h8D, 4'd8);
        apply_stimulus(32'h0000_008D, 8, 0, -1);
        check_output("full_valid_rise", 2, 1);
        check_output("full_len", 4, 8);
        idle(1);
        check_output("full_valid_one_cycle", 2, 0);
        check_output("full_ones", 0, 4);

        // Partial flush, then flush coinciding with the third sample.
        do_reset();
        expect_word(8'h03, 4'd3);
        apply_stimulus(32'h0000_0003, 3, 2, -1);
        idle(2);
        expect_word(8'h03, 4'd3);
        apply_stimulus(32'h0000_0003, 3, 1, -1);
        idle(2);
        flush = 1'b1;
        @(posedge clk); #1;
        idle(2);
        check_output("flush_ones", 0, 4);
        expect_word(8'h5A, 4'd8);
        apply_stimulus(32'h0000_005A, 8, 1, -1);
        idle(3);
        check_output("flush_complete_ones", 0, 8);
        check_output("flush_queue_empty", 6, 0);

        // Backpressure: third word dropped, drain yields exactly two.
        do_reset();
        bus.WORD_READY = 1'b0;
        expect_word(8'hFF, 4'd8);
        expect_word(8'hFF, 4'd8);
        apply_stimulus(32'h00FF_FFFF, 24, 0, -1);
        idle(1);
        check_output("bp_drop", 1, 1);
        check_output("bp_valid_held", 2, 1);
        check_output("bp_word_held", 3, 32'hFF);
        check_output("bp_ones", 0, 24);
        idle(4);
        check_output("bp_drop_sticky", 1, 1);
        bus.WORD_READY = 1'b1;
        idle(5);
        check_output("bp_drained", 6, 0);
        check_output("bp_valid_after_drain", 2, 0);
        check_output("bp_drop_after_drain", 1, 1);

        // Third word completes in the same cycle as a pop on a full buffer.
        do_reset();
        bus.WORD_READY = 1'b0;
        expect_word(8'hFF, 4'd8);
        expect_word(8'hFF, 4'd8);
        expect_word(8'h3C, 4'd8);
        apply_stimulus(32'h0000_FFFF, 16, 0, -1);
        idle(1);
        apply_stimulus(32'h0000_003C, 8, 0, LAT + 7);
        check_output("pp_no_drop", 1, 0);
        check_output("pp_valid", 2, 1);
        bus.WORD_READY = 1'b1;
        idle(4);
        check_output("pp_drained", 6, 0);
        check_output("pp_drop_final", 1, 0);

        // Saturation of a 4-bit counter.
        do_reset();
        expect_word(8'hFF, 4'd8);
        expect_word(8'hFF, 4'd8);
        apply_stimulus(32'h000F_FFFF, 20, 0, -1);
        idle(1);
        check_output("sat_ones_20", 5, 15);
        check_output("main_ones_20", 0, 20);
        expect_word(8'hFF, 4'd8);
        apply_stimulus(32'h0000_000F, 4, 0, -1);
        idle(2);
        check_output("sat_ones_hold", 5, 15);
        check_output("main_ones_24", 0, 24);
        check_output("final_queue_empty", 6, 0);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
